sprite_rom_arbiter: RTL

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_rom_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM read port among NUM_REQ requesters.
// Fixed two-cycle grant-to-response pipeline; out-of-range requests return an error response.
module sprite_rom_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int SPRITE_DIM     = 50,
    parameter int SPRITE_COUNT   = 94,
    parameter int ROM_ADDR_WIDTH = 18,
    localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk_25mHz,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [7*NUM_REQ-1:0]      req_glyph,
    input  logic [6*NUM_REQ-1:0]      req_row,
    input  logic [6*NUM_REQ-1:0]      req_col,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic                      rom_data,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_pixel,
    output logic                      rsp_err
);

    logic [6:0] glyph_arr [NUM_REQ];
    logic [5:0] row_arr   [NUM_REQ];
    logic [5:0] col_arr   [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign glyph_arr[gi] = req_glyph[7*gi +: 7];
            assign row_arr[gi]   = req_row[6*gi +: 6];
            assign col_arr[gi]   = req_col[6*gi +: 6];
        end
    endgenerate

    logic [ID_W-1:0]           ptr_reg;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_reg;
    logic                      s1_valid_reg;
    logic [ID_W-1:0]           s1_id_reg;
    logic                      s1_err_reg;
    logic                      rsp_valid_reg;
    logic [ID_W-1:0]           rsp_id_reg;
    logic                      rsp_err_reg;

    // (base + off) mod NUM_REQ, valid for base, off < NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + (ID_W+1)'(off);
        if (sum >= (ID_W+1)'(NUM_REQ))
            sum = sum - (ID_W+1)'(NUM_REQ);
        return sum[ID_W-1:0];
    endfunction

    logic [ID_W-1:0] sel_idx;
    logic            sel_any;

    // Scan from the highest offset down so the requester closest to ptr wins.
    always_comb begin
        sel_idx = '0;
        sel_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_add(ptr_reg, k)]) begin
                sel_any = 1'b1;
                sel_idx = wrap_add(ptr_reg, k);
            end
        end
    end

    logic grant;
    assign grant = sel_any & ~reset;
    assign gnt   = grant ? (NUM_REQ'(1) << sel_idx) : '0;

    logic [6:0]  glyph_sel;
    logic [5:0]  row_sel;
    logic [5:0]  col_sel;
    logic        in_range;
    logic [31:0] full_addr;

    assign glyph_sel = glyph_arr[sel_idx];
    assign row_sel   = row_arr[sel_idx];
    assign col_sel   = col_arr[sel_idx];

    assign in_range  = (32'(glyph_sel) < 32'(SPRITE_COUNT)) &&
                       (32'(row_sel)   < 32'(SPRITE_DIM))   &&
                       (32'(col_sel)   < 32'(SPRITE_DIM));

    // Full 32-bit product so nothing wraps before the final narrowing to the ROM width.
    assign full_addr = 32'(glyph_sel) * 32'(SPRITE_DIM * SPRITE_DIM)
                     + 32'(row_sel) * 32'(SPRITE_DIM)
                     + 32'(col_sel);

    always_ff @(posedge clk_25mHz) begin
        if (reset) begin
            ptr_reg       <= '0;
            rom_addr_reg  <= '0;
            s1_valid_reg  <= 1'b0;
            s1_id_reg     <= '0;
            s1_err_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            if (frame_start)
                ptr_reg <= '0;
            else if (grant)
                ptr_reg <= wrap_add(sel_idx, 1);

            if (grant && in_range)
                rom_addr_reg <= ROM_ADDR_WIDTH'(full_addr);

            s1_valid_reg  <= grant;
            s1_id_reg     <= grant ? sel_idx : '0;
            s1_err_reg    <= grant & ~in_range;

            rsp_valid_reg <= s1_valid_reg;
            rsp_id_reg    <= s1_valid_reg ? s1_id_reg : '0;
            rsp_err_reg   <= s1_valid_reg & s1_err_reg;
        end
    end

    assign rom_addr  = rom_addr_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_err   = rsp_err_reg;
    // The ROM output lands in the response cycle itself, so the pixel is gated rather than registered.
    assign rsp_pixel = rsp_valid_reg & ~rsp_err_reg & rom_data;

endmodule
